// File: rtl/prga_decrypt_pkg.sv
// prga_decrypt_pkg: shared FSM encoding, RC4 byte type and plaintext character bounds.
package prga_decrypt_pkg;
    typedef logic [7:0] rc4_byte_t;
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        INC_I  = 4'd1,
        RD_SI  = 4'd2,
        UPD_J  = 4'd3,
        RD_SJ  = 4'd4,
        WR_SJ  = 4'd5,
        WR_SI  = 4'd6,
        RD_F   = 4'd7,
        WR_DEC = 4'd8,
        NEXT   = 4'd9,
        DONE   = 4'd10
    } state_t;
    localparam rc4_byte_t CH_SPACE = 8'h20;
    localparam rc4_byte_t CH_LO    = 8'h61;
    localparam rc4_byte_t CH_HI    = 8'h7A;
    function automatic logic char_ok(input rc4_byte_t b);
        return b == CH_SPACE || (b >= CH_LO && b <= CH_HI);
    endfunction
endpackage

// File: rtl/prga_decrypt_wait.sv
// mem_wait_counter: counts RD_LAT cycles while a read is active; ready on the capture cycle.
module mem_wait_counter #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active,
    output logic ready
);
    localparam int W = RD_LAT > 0 ? $clog2(RD_LAT + 1) : 1;
    logic [W-1:0] r_cnt;
    assign ready = active && r_cnt == W'(RD_LAT);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_cnt <= '0;
        else r_cnt <= (active && !ready) ? r_cnt + 1'b1 : '0;
endmodule

// File: rtl/prga_decrypt.sv
// prga_decrypt: RC4 PRGA stage decrypting MSG_LENGTH bytes over an external S-box RAM.
// Optional PRGA_CHAR_CHECK_EN stops on the first non-lowercase/space plaintext byte.
module prga_decrypt
    import prga_decrypt_pkg::*;
#(
    parameter int MSG_LENGTH = 32,
    parameter int RD_LAT     = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    output logic                          done,
    output logic [7:0]                    s_addr,
    output logic [7:0]                    s_wdata,
    output logic                          s_wren,
    input  logic [7:0]                    s_rdata,
    output logic [$clog2(MSG_LENGTH)-1:0] enc_addr,
    input  logic [7:0]                    enc_rdata,
    output logic [$clog2(MSG_LENGTH)-1:0] dec_addr,
    output logic [7:0]                    dec_wdata,
    output logic                          dec_wren
`ifdef PRGA_CHAR_CHECK_EN
    ,output logic                         char_invalid
`endif
);
    localparam int KW = $clog2(MSG_LENGTH);
    state_t    r_state;
    rc4_byte_t r_i, r_j, r_si, r_sj, r_f, r_enc;
    logic [KW-1:0] r_k;
    logic      w_ready, w_last, w_bad;
    rc4_byte_t w_plain;
    assign w_plain = r_f ^ r_enc;
    assign w_last  = r_k == KW'(MSG_LENGTH - 1);
`ifdef PRGA_CHAR_CHECK_EN
    logic r_inv;
    logic w_go;
    assign w_go         = start && (r_state == IDLE || r_state == DONE);
    assign w_bad        = !char_ok(w_plain);
    assign char_invalid = r_inv;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_inv <= 1'b0;
        else if (w_go) r_inv <= 1'b0;
        else if (r_state == WR_DEC && w_bad) r_inv <= 1'b1;
`else
    assign w_bad = 1'b0;
`endif
    mem_wait_counter #(.RD_LAT(RD_LAT)) u_wait (
        .clk    (clk),
        .reset_n(reset_n),
        .active (r_state == RD_SI || r_state == RD_SJ || r_state == RD_F),
        .ready  (w_ready)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_si    <= '0;
            r_sj    <= '0;
            r_f     <= '0;
            r_enc   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: if (start) begin
                    r_i     <= '0;
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= INC_I;
                end
                INC_I: begin
                    r_i     <= r_i + 1'b1;
                    r_state <= RD_SI;
                end
                RD_SI: if (w_ready) begin
                    r_si    <= s_rdata;
                    r_state <= UPD_J;
                end
                UPD_J: begin
                    r_j     <= r_j + r_si;
                    r_state <= RD_SJ;
                end
                RD_SJ: if (w_ready) begin
                    r_sj    <= s_rdata;
                    r_state <= WR_SJ;
                end
                WR_SJ: r_state <= WR_SI;
                WR_SI: r_state <= RD_F;
                RD_F: if (w_ready) begin
                    r_f     <= s_rdata;
                    r_enc   <= enc_rdata;
                    r_state <= WR_DEC;
                end
                WR_DEC: r_state <= w_bad ? DONE : NEXT;
                NEXT: begin
                    r_state <= w_last ? DONE : INC_I;
                    if (!w_last) r_k <= r_k + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    // Outputs decode straight from registered state so reset clears them at once.
    assign done      = r_state == DONE;
    assign s_wren    = r_state == WR_SJ || r_state == WR_SI;
    assign s_addr    = (r_state == RD_SI || r_state == WR_SI) ? r_i :
                       (r_state == RD_SJ || r_state == WR_SJ) ? r_j :
                       r_state == RD_F ? r_si + r_sj : '0;
    assign s_wdata   = r_state == WR_SJ ? r_si : r_state == WR_SI ? r_sj : '0;
    assign enc_addr  = r_state == RD_F ? r_k : '0;
    assign dec_wren  = r_state == WR_DEC;
    assign dec_addr  = dec_wren ? r_k : '0;
    assign dec_wdata = dec_wren ? w_plain : '0;
endmodule

// File: tb/tb_prga_decrypt.sv
// tb_prga_decrypt: latency-accurate memory models around prga_decrypt checked against a plain RC4 PRGA model.
module tb_prga_decrypt;
    import prga_decrypt_pkg::*;
    localparam int ML = 32;
    localparam int RL = 2;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic done, s_wren, dec_wren;
    logic [7:0] s_addr, s_wdata, s_rdata, enc_rdata, dec_wdata;
    logic [4:0] enc_addr, dec_addr;
`ifdef PRGA_CHAR_CHECK_EN
    logic char_invalid;
`endif
    int vectors = 0;
    int miscompares = 0;
    int viol = 0;
    logic [7:0] smem [256];
    logic [7:0] emem [ML];
    logic [7:0] dmem [ML];
    logic [7:0] sa_p [RL];
    logic [4:0] ea_p [RL];
    logic [23:0] snap;
    int dlog [$];
    logic [15:0] swlog [$];
    int ms [256];
    logic [7:0] me [ML];
    logic [7:0] md [ML];
    int mcnt;

    prga_decrypt #(.MSG_LENGTH(ML), .RD_LAT(RL)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .done(done),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
        .enc_addr(enc_addr), .enc_rdata(enc_rdata),
        .dec_addr(dec_addr), .dec_wdata(dec_wdata), .dec_wren(dec_wren)
`ifdef PRGA_CHAR_CHECK_EN
        , .char_invalid(char_invalid)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        sa_p[0] <= s_addr;
        ea_p[0] <= enc_addr;
        for (int n = 1; n < RL; n++) begin
            sa_p[n] <= sa_p[n-1];
            ea_p[n] <= ea_p[n-1];
        end
        if (s_wren) begin
            smem[s_addr] <= s_wdata;
            swlog.push_back({s_addr, s_wdata});
        end
        if (dec_wren) begin
            dmem[dec_addr] <= dec_wdata;
            dlog.push_back(int'(dec_addr));
            if (dec_addr == 5'd2) snap <= {smem[2], smem[3], smem[5]};
        end
        if (s_wren && dec_wren) viol <= viol + 1;
    end
    assign s_rdata   = smem[sa_p[RL-1]];
    assign enc_rdata = emem[ea_p[RL-1]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input bit rnd_s, input bit rnd_e);
        int p [256];
        int t, r;
        for (int n = 0; n < 256; n++) p[n] = n;
        if (rnd_s)
            for (int n = 255; n > 0; n--) begin
                r = int'($urandom_range(n, 0));
                t = p[n]; p[n] = p[r]; p[r] = t;
            end
        @(negedge clk);
        for (int n = 0; n < 256; n++) begin
            smem[n] <= 8'(p[n]);
            ms[n] = p[n];
        end
        for (int k = 0; k < ML; k++) begin
            emem[k] = rnd_e ? 8'($urandom_range(255, 0)) : 8'h00;
            me[k] = emem[k];
        end
        @(negedge clk);
    endtask

    task automatic set_enc(input int k, input logic [7:0] v);
        emem[k] = v;
        me[k] = v;
    endtask

    task automatic model_run();
        int i, j, t;
        i = 0; j = 0; mcnt = 0;
        for (int k = 0; k < ML; k++) begin
            i = (i + 1) % 256;
            j = (j + ms[i]) % 256;
            t = ms[i]; ms[i] = ms[j]; ms[j] = t;
            md[k] = 8'(ms[(ms[i] + ms[j]) % 256]) ^ me[k];
            mcnt++;
`ifdef PRGA_CHAR_CHECK_EN
            if (!(md[k] == 8'h20 || (md[k] >= 8'h61 && md[k] <= 8'h7A))) break;
`endif
        end
    endtask

    task automatic pulse_start();
        dlog.delete();
        swlog.delete();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c = 0;
        while (!done && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_done_in_time"}, 32'(done), 32'd1);
    endtask

    task automatic compare_run(input string tag);
        int bad;
        check({tag, "_count"}, dlog.size(), mcnt);
        for (int k = 0; k < mcnt; k++) check($sformatf("%s_dec%0d", tag, k), 32'(dmem[k]), 32'(md[k]));
        bad = 0;
        for (int n = 0; n < dlog.size(); n++) if (dlog[n] != n) bad++;
        check({tag, "_addr_order"}, bad, 0);
        bad = 0;
        for (int n = 0; n < 256; n++) if (smem[n] !== 8'(ms[n])) bad++;
        check({tag, "_sbox"}, bad, 0);
    endtask

    initial begin
        int held, c;
        repeat (3) @(negedge clk);
        check("rst_s", {s_addr, s_wdata, 7'd0, s_wren}, 0);
        check("rst_dec", {dec_addr, enc_addr, dec_wdata, dec_wren, done}, 0);
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_quiet", {s_wren, dec_wren, s_addr, enc_addr, dec_addr, done}, 0);
        end

        load(1'b0, 1'b0);
        model_run();
        pulse_start();
        wait_done("ident");
        held = 0;
        repeat (12) begin
            @(negedge clk);
            held += int'(done);
        end
        check("done_held", held, 12);
        check("ident_dec0", 32'(dmem[0]), 32'h02);
`ifndef PRGA_CHAR_CHECK_EN
        check("ident_dec1", 32'(dmem[1]), 32'h05);
        check("ident_dec2", 32'(dmem[2]), 32'h07);
        check("ident_s_k2", 32'(snap), 32'h030502);
        check("ident_pulses", dlog.size(), 32);
`endif
        compare_run("ident");

        load(1'b0, 1'b0);
        set_enc(0, 8'h61);
        model_run();
        pulse_start();
        wait_done("ieqj");
        check("ieqj_dec0", 32'(dmem[0]), 32'h63);
        check("ieqj_sw0", 32'(swlog[0]), 32'h0101);
        check("ieqj_sw1", 32'(swlog[1]), 32'h0101);
        compare_run("ieqj");

        repeat (3) begin
            load(1'b1, 1'b1);
            model_run();
            pulse_start();
            wait_done("rand");
            compare_run("rand");
        end

        load(1'b0, 1'b0);
        pulse_start();
        c = 0;
        while (!(dut.r_state == RD_SJ && dut.r_k == 5'd5) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check("reach_rd_sj_k5", 32'(c < 3000), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_s", {s_addr, s_wdata, 7'd0, s_wren}, 0);
        check("midrst_dec", {dec_addr, enc_addr, dec_wdata, dec_wren, done}, 0);
        @(negedge clk) reset_n = 1'b1;
        load(1'b0, 1'b0);
        model_run();
        pulse_start();
        wait_done("restart");
        check("restart_dec0", 32'(dmem[0]), 32'h02);
`ifndef PRGA_CHAR_CHECK_EN
        check("restart_dec1", 32'(dmem[1]), 32'h05);
        check("restart_dec2", 32'(dmem[2]), 32'h07);
`endif
        compare_run("restart");

        load(1'b1, 1'b1);
        model_run();
        pulse_start();
        c = 0;
        while (dut.r_state != WR_SI && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check("reach_wr_si", 32'(c < 3000), 32'd1);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done("midstart");
        compare_run("midstart");

`ifdef PRGA_CHAR_CHECK_EN
        load(1'b0, 1'b0);
        set_enc(0, 8'h63);
        set_enc(1, 8'h64);
        set_enc(2, 8'h66);
        set_enc(3, 8'h76);
        model_run();
        pulse_start();
        wait_done("chk");
        check("chk_writes", dlog.size(), 4);
        check("chk_done", 32'(done), 32'd1);
        check("chk_invalid", 32'(char_invalid), 32'd1);
        check("chk_dec3", 32'(dmem[3]), 32'h7B);
        compare_run("chk");
`endif
        check("wren_exclusive", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
